// File: rtl/pp_unpack_st3_if.sv
// Handshake bundle for the stage-3 unpack buffer.
// Wide rows enter on the in_* side. Per-channel narrow beats leave on the out_* side.
interface pp_unpack_st3_if #(
    parameter int WIDE_WIDTH   = 8192,
    parameter int NARROW_WIDTH = 64,
    parameter int CHANNEL_NUM  = 4
);
    logic                    in_vld;
    logic                    in_rdy;
    logic [WIDE_WIDTH-1:0]   in_data;
    logic                    out_vld;
    logic                    out_rdy;
    logic [NARROW_WIDTH-1:0] out_data [CHANNEL_NUM];
    logic                    out_last;

    modport master (
        output in_vld, in_data, out_rdy,
        input  in_rdy, out_vld, out_data, out_last
    );

    modport slave (
        input  in_vld, in_data, out_rdy,
        output in_rdy, out_vld, out_data, out_last
    );
endinterface

// File: rtl/pp_unpack_st3.sv
// Decoder stage-3 ping-pong unpack buffer.
// Takes CHANNEL_NUM wide rows per bank and drains each bank as one NARROW_WIDTH chunk per channel per beat.
module pp_unpack_st3 #(
    parameter int WIDE_WIDTH   = 8192,
    parameter int NARROW_WIDTH = 64,
    parameter int CHANNEL_NUM  = 4
) (
    input  logic              clk,
    input  logic              rst,
    pp_unpack_st3_if.slave    bus
);
    localparam int CHUNKS = WIDE_WIDTH / NARROW_WIDTH;
    localparam int ROW_W  = $clog2(CHANNEL_NUM);
    localparam int IDX_W  = $clog2(CHUNKS);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(CHANNEL_NUM - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CHUNKS - 1);

    // Rows are stored chunk-major so a read is a plain index, not a multiplied offset.
    logic [CHUNKS-1:0][NARROW_WIDTH-1:0] mem [2][CHANNEL_NUM];

    logic [1:0]              full;
    logic                    wr_sel;
    logic                    rd_sel;
    logic [ROW_W-1:0]        wr_row;
    logic [IDX_W-1:0]        rd_idx;
    logic                    out_vld;
    logic                    out_last;
    logic [NARROW_WIDTH-1:0] out_data [CHANNEL_NUM];
    logic                    wr_en;
    logic                    load;

    assign bus.in_rdy = ~full[wr_sel];
    assign wr_en      = bus.in_vld & ~full[wr_sel];
    assign load       = full[rd_sel] & (~out_vld | bus.out_rdy);

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_sel][wr_row] <= bus.in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            full     <= 2'b00;
            wr_sel   <= 1'b0;
            rd_sel   <= 1'b0;
            wr_row   <= '0;
            rd_idx   <= '0;
            out_vld  <= 1'b0;
            out_last <= 1'b0;
            for (int c = 0; c < CHANNEL_NUM; c++) begin
                out_data[c] <= '0;
            end
        end else begin
            if (wr_en) begin
                if (wr_row == LAST_ROW) begin
                    full[wr_sel] <= 1'b1;
                    wr_sel       <= ~wr_sel;
                    wr_row       <= '0;
                end else begin
                    wr_row <= wr_row + 1'b1;
                end
            end

            // The bank being cleared is never the bank being filled, so both updates land.
            if (load) begin
                for (int c = 0; c < CHANNEL_NUM; c++) begin
                    out_data[c] <= mem[rd_sel][c][rd_idx];
                end
                out_vld  <= 1'b1;
                out_last <= (rd_idx == LAST_IDX);
                if (rd_idx == LAST_IDX) begin
                    full[rd_sel] <= 1'b0;
                    rd_sel       <= ~rd_sel;
                    rd_idx       <= '0;
                end else begin
                    rd_idx <= rd_idx + 1'b1;
                end
            end else if (bus.out_rdy) begin
                out_vld  <= 1'b0;
                out_last <= 1'b0;
            end
        end
    end

    assign bus.out_vld  = out_vld;
    assign bus.out_last = out_last;
    assign bus.out_data = out_data;
endmodule

// File: tb/tb_pp_unpack_st3.sv
// Directed bench for pp_unpack_st3: a full-size instance plus a small 256/64/2 instance.
// Row r of frame tag t holds chunk k = {r[7:0], t[7:0], k[47:0]}.
module tb_pp_unpack_st3;
    localparam int WW = 8192;
    localparam int NW = 64;
    localparam int CH = 4;
    localparam int CK = WW / NW;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pp_unpack_st3_if #(.WIDE_WIDTH(WW), .NARROW_WIDTH(NW), .CHANNEL_NUM(CH)) bus ();
    pp_unpack_st3_if #(.WIDE_WIDTH(256), .NARROW_WIDTH(64), .CHANNEL_NUM(2)) bus6 ();

    pp_unpack_st3 #(.WIDE_WIDTH(WW), .NARROW_WIDTH(NW), .CHANNEL_NUM(CH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    pp_unpack_st3 #(.WIDE_WIDTH(256), .NARROW_WIDTH(64), .CHANNEL_NUM(2)) dut6 (
        .clk (clk),
        .rst (rst),
        .bus (bus6.slave)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [WW-1:0] make_row(input int tag, input int r);
        logic [WW-1:0] row;
        for (int k = 0; k < CK; k++) row[k*NW +: NW] = {8'(r), 8'(tag), 48'(k)};
        return row;
    endfunction

    function automatic logic [255:0] exp_beat(input int tag, input int k);
        logic [255:0] e;
        for (int c = 0; c < CH; c++) e[c*NW +: NW] = {8'(c), 8'(tag), 48'(k)};
        return e;
    endfunction

    // Output scoreboard: frame tags in acceptance order, beat index within the head frame.
    int           exp_q [$];
    int           mon_k      = 0;
    int           beats_seen = 0;
    int           last_cnt   = 0;
    logic         held       = 1'b0;
    logic [255:0] held_data;
    logic [255:0] mon_obs;

    always @(negedge clk) begin
        if (!rst && bus.out_vld) begin
            for (int c = 0; c < CH; c++) mon_obs[c*NW +: NW] = bus.out_data[c];
            if (held) chk("hold under backpressure", mon_obs, held_data);
            if (bus.out_rdy) begin
                if (exp_q.size() == 0) begin
                    chk("spurious beat", 256'(1), 256'(0));
                end else begin
                    chk("beat data", mon_obs, exp_beat(exp_q[0], mon_k));
                    chk("beat last", 256'(bus.out_last), 256'(mon_k == CK - 1));
                    if (bus.out_last) last_cnt++;
                    beats_seen++;
                    if (mon_k == CK - 1) begin
                        mon_k = 0;
                        void'(exp_q.pop_front());
                    end else begin
                        mon_k++;
                    end
                end
                held = 1'b0;
            end else begin
                held      = 1'b1;
                held_data = mon_obs;
            end
        end else begin
            held = 1'b0;
        end
    end

    task automatic send_row(input int tag, input int r);
        int   n = 0;
        logic acc;
        bus.in_vld  = 1'b1;
        bus.in_data = make_row(tag, r);
        forever begin
            @(negedge clk);
            acc = bus.in_rdy;
            @(posedge clk);
            #1;
            if (acc) break;
            n++;
            if (n > 1000) begin
                chk("in_rdy wait timeout", 256'(0), 256'(1));
                break;
            end
        end
        bus.in_vld = 1'b0;
        if (r == CH - 1) exp_q.push_back(tag);
    endtask

    task automatic send_frame(input int tag);
        for (int r = 0; r < CH; r++) send_row(tag, r);
    endtask

    task automatic wait_drain(input int limit);
        int n = 0;
        while ((exp_q.size() != 0 || bus.out_vld) && n < limit) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain within budget", 256'(n < limit), 256'(1));
    endtask

    int b0;
    int l0;
    int n;
    int bubbles;
    logic [255:0] obs0;
    logic [127:0] obs6;
    logic [127:0] exp6;

    initial begin
        rst           = 1'b1;
        bus.in_vld    = 1'b0;
        bus.in_data   = '0;
        bus.out_rdy   = 1'b0;
        bus6.in_vld   = 1'b0;
        bus6.in_data  = '0;
        bus6.out_rdy  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        for (int c = 0; c < CH; c++) obs0[c*NW +: NW] = bus.out_data[c];
        chk("reset in_rdy", 256'(bus.in_rdy), 256'(1));
        chk("reset out_vld", 256'(bus.out_vld), 256'(0));
        chk("reset out_last", 256'(bus.out_last), 256'(0));
        chk("reset out_data", obs0, 256'(0));
        chk("reset small in_rdy", 256'(bus6.in_rdy), 256'(1));
        chk("reset small out_vld", 256'(bus6.out_vld), 256'(0));

        // T1 single frame, first-beat latency
        bus.out_rdy = 1'b1;
        b0 = beats_seen;
        l0 = last_cnt;
        send_frame(0);
        chk("t1 out_vld low at full edge", 256'(bus.out_vld), 256'(0));
        @(posedge clk);
        #1;
        chk("t1 out_vld one cycle later", 256'(bus.out_vld), 256'(1));
        wait_drain(400);
        chk("t1 beat count", 256'(beats_seen - b0), 256'(CK));
        chk("t1 last count", 256'(last_cnt - l0), 256'(1));

        // T2 random backpressure
        b0 = beats_seen;
        l0 = last_cnt;
        send_frame(1);
        repeat (300) begin
            @(posedge clk);
            #1;
            bus.out_rdy = 1'($urandom_range(0, 1));
        end
        bus.out_rdy = 1'b1;
        wait_drain(400);
        chk("t2 beat count", 256'(beats_seen - b0), 256'(CK));
        chk("t2 last count", 256'(last_cnt - l0), 256'(1));

        // T3 both banks full
        b0 = beats_seen;
        l0 = last_cnt;
        bus.out_rdy = 1'b0;
        send_frame(2);
        send_frame(3);
        chk("t3 in_rdy low after row 7", 256'(bus.in_rdy), 256'(0));
        bus.in_vld  = 1'b1;
        bus.in_data = make_row(4, 0);
        repeat (5) begin
            @(posedge clk);
            #1;
            chk("t3 ninth row refused", 256'(bus.in_rdy), 256'(0));
        end
        bus.in_vld  = 1'b0;
        bus.out_rdy = 1'b1;
        n = 0;
        while (!bus.in_rdy && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("t3 in_rdy rise after chunk 127", 256'(n), 256'(127));
        wait_drain(600);
        chk("t3 beat count", 256'(beats_seen - b0), 256'(2 * CK));
        chk("t3 last count", 256'(last_cnt - l0), 256'(2));

        // T4 streaming 10 frames
        b0 = beats_seen;
        l0 = last_cnt;
        bubbles = 0;
        fork
            for (int f = 0; f < 10; f++) send_frame(10 + f);
            begin
                int m = 0;
                while (!bus.out_vld && m < 100) begin
                    @(posedge clk);
                    #1;
                    m++;
                end
                while (beats_seen < b0 + 10 * CK && m < 5000) begin
                    @(posedge clk);
                    #1;
                    m++;
                    if (!bus.out_vld && beats_seen < b0 + 10 * CK) bubbles++;
                end
            end
        join
        wait_drain(400);
        chk("t4 no bubbles", 256'(bubbles), 256'(0));
        chk("t4 beat count", 256'(beats_seen - b0), 256'(10 * CK));
        chk("t4 last count", 256'(last_cnt - l0), 256'(10));

        // T5 reset with frame 0 partly drained and 2 rows of frame 1 written
        send_frame(20);
        repeat (10) @(posedge clk);
        #1;
        send_row(21, 0);
        send_row(21, 1);
        rst = 1'b1;
        exp_q.delete();
        mon_k = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("t5 out_vld after reset", 256'(bus.out_vld), 256'(0));
        chk("t5 in_rdy after reset", 256'(bus.in_rdy), 256'(1));
        b0 = beats_seen;
        send_frame(22);
        wait_drain(400);
        chk("t5 clean frame beats", 256'(beats_seen - b0), 256'(CK));

        // T6 small instance: 4 beats per frame, 2 channels
        bus6.out_rdy = 1'b1;
        for (int r = 0; r < 2; r++) begin
            bus6.in_vld = 1'b1;
            for (int k = 0; k < 4; k++) bus6.in_data[k*64 +: 64] = {8'(r), 8'h06, 48'(k)};
            chk("t6 in_rdy", 256'(bus6.in_rdy), 256'(1));
            @(posedge clk);
            #1;
        end
        bus6.in_vld = 1'b0;
        chk("t6 out_vld low at full edge", 256'(bus6.out_vld), 256'(0));
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            obs6 = {bus6.out_data[1], bus6.out_data[0]};
            exp6 = {8'd1, 8'h06, 48'(k), 8'd0, 8'h06, 48'(k)};
            chk("t6 out_vld", 256'(bus6.out_vld), 256'(1));
            chk("t6 data", 256'(obs6), 256'(exp6));
            chk("t6 last", 256'(bus6.out_last), 256'(k == 3));
        end
        @(posedge clk);
        #1;
        chk("t6 out_vld falls when empty", 256'(bus6.out_vld), 256'(0));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
